// File: rtl/axi_burst_to_bulk_read.sv
// AXI4 read-only slave: splits full-width INCR bursts into bulk-read chunks (<= BULK_MAX_BEATS,
// never crossing 4 KiB) and returns the data through a 2-entry registered skid FIFO.
module axi_burst_to_bulk_read #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned BULK_MAX_BEATS = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              ar_valid_i,
  output logic                              ar_ready_o,
  input  logic [ADDR_W-1:0]                 ar_addr_i,
  input  logic [7:0]                        ar_len_i,
  output logic                              r_valid_o,
  input  logic                              r_ready_i,
  output logic [DATA_W-1:0]                 r_data_o,
  output logic [1:0]                        r_resp_o,
  output logic                              r_last_o,
  output logic                              bulk_req_valid_o,
  input  logic                              bulk_req_ready_i,
  output logic [ADDR_W-1:0]                 bulk_req_addr_o,
  output logic [$clog2(BULK_MAX_BEATS):0]   bulk_req_beats_o,
  input  logic                              bulk_data_valid_i,
  output logic                              bulk_data_ready_o,
  input  logic [DATA_W-1:0]                 bulk_data_i,
  input  logic                              bulk_data_err_i
);

  localparam int unsigned Bytes  = DATA_W / 8;
  localparam int unsigned ByteW  = $clog2(Bytes);
  localparam int unsigned BeatsW = $clog2(BULK_MAX_BEATS) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StStream, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          remain_q, remain_d;
  logic [BeatsW-1:0]   cnt_q, cnt_d;
  logic [BeatsW-1:0]   chunk;
  logic [12:0]         page_beats;

  logic [DATA_W-1:0]   fdata_q [2];
  logic [1:0]          ferr_q, flast_q;
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          count_q;
  logic                fifo_full, fifo_empty;
  logic                push, push_last, pop;

  function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
    return (a < b) ? a : b;
  endfunction

  // Beats left before the next 4 KiB page boundary (1..4096/Bytes).
  assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> ByteW;
  assign chunk      = BeatsW'(min13(min13(13'(remain_q), 13'(BULK_MAX_BEATS)), page_beats));

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign pop        = r_valid_o & r_ready_i;

  assign bulk_req_addr_o = addr_q;

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    remain_d          = remain_q;
    cnt_d             = cnt_q;
    ar_ready_o        = 1'b0;
    bulk_req_valid_o  = 1'b0;
    bulk_req_beats_o  = '0;
    bulk_data_ready_o = 1'b0;
    push              = 1'b0;
    push_last         = 1'b0;
    case (state_q)
      StIdle: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          addr_d   = ar_addr_i & ~ADDR_W'(Bytes - 1);
          remain_d = {1'b0, ar_len_i} + 9'd1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        bulk_req_valid_o = 1'b1;
        bulk_req_beats_o = chunk;
        if (bulk_req_ready_i) begin
          cnt_d    = chunk;
          addr_d   = addr_q + (ADDR_W'(chunk) << ByteW);
          remain_d = remain_q - 9'(chunk);
          state_d  = StStream;
        end
      end
      StStream: begin
        bulk_data_ready_o = ~fifo_full;
        if (bulk_data_valid_i && !fifo_full) begin
          push      = 1'b1;
          push_last = (remain_q == 9'd0) && (cnt_q == BeatsW'(1));
          cnt_d     = cnt_q - BeatsW'(1);
          if (cnt_q == BeatsW'(1)) begin
            state_d = (remain_q != 9'd0) ? StIssue : StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && r_last_o) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fdata_q[wr_ptr_q] <= bulk_data_i;
      ferr_q[wr_ptr_q]  <= bulk_data_err_i;
      flast_q[wr_ptr_q] <= push_last;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign r_valid_o = ~fifo_empty;
  assign r_data_o  = fifo_empty ? '0 : fdata_q[rd_ptr_q];
  assign r_resp_o  = {~fifo_empty & ferr_q[rd_ptr_q], 1'b0};
  assign r_last_o  = ~fifo_empty & flast_q[rd_ptr_q];

endmodule

// File: tb/tb_axi_burst_to_bulk_read.sv
// Scoreboard bench for axi_burst_to_bulk_read: directed bursts, a bulk-slave responder, and
// independent monitors for the bulk request and R channels.
module tb_axi_burst_to_bulk_read;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MAXB   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ar_valid, ar_ready;
  logic [31:0]       ar_addr;
  logic [7:0]        ar_len;
  logic              r_valid, r_ready, r_last;
  logic [63:0]       r_data;
  logic [1:0]        r_resp;
  logic              bulk_req_valid, bulk_req_ready;
  logic [31:0]       bulk_req_addr;
  logic [4:0]        bulk_req_beats;
  logic              bulk_data_valid, bulk_data_ready, bulk_data_err;
  logic [63:0]       bulk_data;

  always #5 clk = ~clk;

  axi_burst_to_bulk_read #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .BULK_MAX_BEATS(MAXB)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ar_valid_i       (ar_valid),
    .ar_ready_o       (ar_ready),
    .ar_addr_i        (ar_addr),
    .ar_len_i         (ar_len),
    .r_valid_o        (r_valid),
    .r_ready_i        (r_ready),
    .r_data_o         (r_data),
    .r_resp_o         (r_resp),
    .r_last_o         (r_last),
    .bulk_req_valid_o (bulk_req_valid),
    .bulk_req_ready_i (bulk_req_ready),
    .bulk_req_addr_o  (bulk_req_addr),
    .bulk_req_beats_o (bulk_req_beats),
    .bulk_data_valid_i(bulk_data_valid),
    .bulk_data_ready_o(bulk_data_ready),
    .bulk_data_i      (bulk_data),
    .bulk_data_err_i  (bulk_data_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_req_addr[$];
  int          exp_req_beats[$];
  logic [63:0] exp_r_data[$];
  logic [1:0]  exp_r_resp[$];
  bit          exp_r_last[$];
  logic [31:0] err_addr = 32'h1;
  int          stall = 0;

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Bulk slave: accepts a request one cycle after seeing it, then streams its beats.
  initial begin
    logic [31:0] q_addr[$];
    logic [31:0] cap_addr, hold_addr;
    logic [4:0]  hold_beats;
    int          cap_beats;
    bit          req_hs, dat_hs, seen, hold_chk;
    req_hs = 0; dat_hs = 0; seen = 0; hold_chk = 0;
    cap_addr = '0; cap_beats = 0; hold_addr = '0; hold_beats = '0;
    bulk_req_ready = 1'b0; bulk_data_valid = 1'b0; bulk_data = '0; bulk_data_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q_addr.delete();
        req_hs = 0; dat_hs = 0; seen = 0; hold_chk = 0;
        bulk_req_ready = 1'b0; bulk_data_valid = 1'b0; bulk_data_err = 1'b0;
      end else begin
        if (dat_hs) void'(q_addr.pop_front());
        if (req_hs) for (int i = 0; i < cap_beats; i++) q_addr.push_back(cap_addr + 32'(i * 8));
        if (hold_chk) begin
          check("req_stable_valid", bulk_req_valid, 1);
          check("req_stable_addr", bulk_req_addr, hold_addr);
          check("req_stable_beats", bulk_req_beats, hold_beats);
        end
        hold_chk = 0;
        bulk_req_ready = seen && bulk_req_valid;
        seen = bulk_req_valid && !bulk_req_ready;
        req_hs = bulk_req_valid && bulk_req_ready;
        if (bulk_req_valid && !bulk_req_ready) begin
          hold_chk = 1; hold_addr = bulk_req_addr; hold_beats = bulk_req_beats;
        end
        if (req_hs) begin
          cap_addr  = bulk_req_addr;
          cap_beats = int'(bulk_req_beats);
          if (exp_req_addr.size() == 0) begin
            fail_now("unexpected_bulk_req");
          end else begin
            check("req_addr", bulk_req_addr, exp_req_addr.pop_front());
            check("req_beats", bulk_req_beats, 64'(exp_req_beats.pop_front()));
          end
        end
        if (q_addr.size() > 0) begin
          bulk_data_valid = 1'b1;
          bulk_data       = beat_data(q_addr[0]);
          bulk_data_err   = (q_addr[0] == err_addr);
        end else begin
          bulk_data_valid = 1'b0;
          bulk_data       = '0;
          bulk_data_err   = 1'b0;
        end
        dat_hs = bulk_data_valid && bulk_data_ready;
      end
    end
  end

  // R monitor: drives r_ready (with optional stall) and pops the scoreboard on each beat.
  initial begin
    bit          hold, last_chk;
    logic [63:0] hd;
    logic [1:0]  hr;
    logic        hl;
    hold = 0; last_chk = 0; hd = '0; hr = '0; hl = 1'b0;
    r_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; last_chk = 0; r_ready = 1'b0;
      end else begin
        if (last_chk) check("ar_ready_after_last", ar_ready, 1);
        last_chk = 0;
        if (hold) begin
          check("r_stable_valid", r_valid, 1);
          check("r_stable_data", r_data, hd);
          check("r_stable_resp", r_resp, hr);
          check("r_stable_last", r_last, hl);
        end
        hold = 0;
        if (stall > 0) begin
          stall--;
          r_ready = 1'b0;
        end else begin
          r_ready = 1'b1;
        end
        if (r_valid && r_ready) begin
          if (exp_r_data.size() == 0) begin
            fail_now("unexpected_r_beat");
          end else begin
            check("r_data", r_data, exp_r_data.pop_front());
            check("r_resp", r_resp, exp_r_resp.pop_front());
            last_chk = exp_r_last.pop_front();
            check("r_last", r_last, last_chk);
          end
        end else if (r_valid) begin
          hold = 1; hd = r_data; hr = r_resp; hl = r_last;
        end
      end
    end
  end

  task automatic exp_req(input logic [31:0] a, input int beats);
    exp_req_addr.push_back(a);
    exp_req_beats.push_back(beats);
  endtask

  task automatic burst_start(input logic [31:0] addr, input int len);
    logic [31:0] base, a;
    int t;
    base = addr & ~32'h7;
    for (int i = 0; i <= len; i++) begin
      a = base + 32'(i * 8);
      exp_r_data.push_back(beat_data(a));
      exp_r_resp.push_back((a == err_addr) ? 2'b10 : 2'b00);
      exp_r_last.push_back(i == len);
    end
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = addr; ar_len = 8'(len);
    t = 0;
    while (!ar_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("ar_handshake_timeout");
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(exp_r_data.size() == 0 && exp_req_addr.size() == 0 && ar_ready) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      fail_now("burst_timeout");
      exp_r_data.delete(); exp_r_resp.delete(); exp_r_last.delete();
      exp_req_addr.delete(); exp_req_beats.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ar_ready"}, ar_ready, 1);
    check({tag, "_r_valid"}, r_valid, 0);
    check({tag, "_r_last"}, r_last, 0);
    check({tag, "_r_resp"}, r_resp, 0);
    check({tag, "_r_data"}, r_data, 0);
    check({tag, "_req_valid"}, bulk_req_valid, 0);
    check({tag, "_req_addr"}, bulk_req_addr, 0);
    check({tag, "_req_beats"}, bulk_req_beats, 0);
    check({tag, "_data_ready"}, bulk_data_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_len = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single beat.
    exp_req(32'h100, 1);
    burst_start(32'h100, 0); wait_done();

    // 32 beats split into two max-size chunks.
    exp_req(32'h1000, 16); exp_req(32'h1080, 16);
    burst_start(32'h1000, 31); wait_done();

    // 4 KiB crossing, aligned and unaligned start.
    exp_req(32'h0FF0, 2); exp_req(32'h1000, 2);
    burst_start(32'h0FF0, 3); wait_done();
    exp_req(32'h0FF0, 2); exp_req(32'h1000, 2);
    burst_start(32'h0FF5, 3); wait_done();

    // R back-pressure: FIFO fills after two beats.
    exp_req(32'h200, 8);
    stall = 8;
    burst_start(32'h200, 7);
    repeat (5) @(negedge clk);
    check("stall_bulk_data_ready", bulk_data_ready, 0);
    check("stall_r_valid", r_valid, 1);
    wait_done();

    // Error on the second beat only.
    err_addr = 32'h308;
    exp_req(32'h300, 4);
    burst_start(32'h300, 3); wait_done();
    err_addr = 32'h1;

    // Address space wrap at the top page.
    exp_req(32'hFFFF_FFF8, 1); exp_req(32'h0, 1);
    burst_start(32'hFFFF_FFF8, 1); wait_done();

    // Asynchronous reset in the middle of a stream.
    exp_req(32'h2000, 16);
    burst_start(32'h2000, 15);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    exp_r_data.delete(); exp_r_resp.delete(); exp_r_last.delete();
    exp_req_addr.delete(); exp_req_beats.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_r_valid", r_valid, 0);

    exp_req(32'h3000, 4);
    burst_start(32'h3000, 3); wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
